// File: rtl/multi_issue_dispatch_if.sv
// Decode-queue, issue and write-back buses of the multi-issue dispatch stage.
// The master side is the surrounding core (queue and pipelines); the slave side is the dispatch stage.
interface multi_issue_dispatch_if #(
  parameter int REG_ID_W  = 5,
  parameter int DATA_W    = 64,
  parameter int PAYLOAD_W = 32,
  parameter int ISSUE_W   = 2,
  parameter int NUM_WAYS  = 2
);
  localparam int CNT_W = $clog2(ISSUE_W + 1);

  logic [CNT_W-1:0]              mop_avail;
  logic [ISSUE_W*REG_ID_W-1:0]   mop_src0;
  logic [ISSUE_W*REG_ID_W-1:0]   mop_src1;
  logic [ISSUE_W*REG_ID_W-1:0]   mop_dst;
  logic [ISSUE_W*PAYLOAD_W-1:0]  mop_payload;
  logic [CNT_W-1:0]              deq_cnt;

  logic [NUM_WAYS-1:0]           way_busy;
  logic [NUM_WAYS-1:0]           iss_valid;
  logic [NUM_WAYS*DATA_W-1:0]    iss_src0_val;
  logic [NUM_WAYS*DATA_W-1:0]    iss_src1_val;
  logic [NUM_WAYS*REG_ID_W-1:0]  iss_dst;
  logic [NUM_WAYS*PAYLOAD_W-1:0] iss_payload;

  logic [NUM_WAYS-1:0]           wb_valid;
  logic [NUM_WAYS*REG_ID_W-1:0]  wb_dst;
  logic [NUM_WAYS*DATA_W-1:0]    wb_val;

  modport master (
    output mop_avail, mop_src0, mop_src1, mop_dst, mop_payload,
    output way_busy, wb_valid, wb_dst, wb_val,
    input  deq_cnt, iss_valid, iss_src0_val, iss_src1_val, iss_dst, iss_payload
  );

  modport slave (
    input  mop_avail, mop_src0, mop_src1, mop_dst, mop_payload,
    input  way_busy, wb_valid, wb_dst, wb_val,
    output deq_cnt, iss_valid, iss_src0_val, iss_src1_val, iss_dst, iss_payload
  );
endinterface

// File: rtl/multi_issue_dispatch.sv
// Register-read, dispatch and write-back stage: picks an in-order prefix of hazard-free
// micro-ops each cycle, reads their sources (with write-back bypass) and issues them to
// the free execution ways; write-backs update the register file and scoreboard.
module multi_issue_dispatch #(
  parameter int NUM_REGS  = 16,
  parameter int REG_ID_W  = 5,
  parameter int DATA_W    = 64,
  parameter int PAYLOAD_W = 32,
  parameter int ISSUE_W   = 2,
  parameter int NUM_WAYS  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  multi_issue_dispatch_if.slave bus,
  output logic [NUM_REGS-1:0]  sb_pending,
  output logic [31:0]          stall_cnt,
  output logic                 err_wb
);
  localparam int CNT_W  = $clog2(ISSUE_W + 1);
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int SLOT_W = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1;
  localparam logic [REG_ID_W:0] NREG_LIM = (REG_ID_W + 1)'(NUM_REGS);

  logic [DATA_W-1:0]    rf [NUM_REGS];
  logic [REG_ID_W-1:0]  wb_id [NUM_WAYS];
  logic [DATA_W-1:0]    wb_data [NUM_WAYS];
  logic [REG_ID_W-1:0]  s0_id [ISSUE_W];
  logic [REG_ID_W-1:0]  s1_id [ISSUE_W];
  logic [REG_ID_W-1:0]  d_id [ISSUE_W];
  logic [PAYLOAD_W-1:0] s_pay [ISSUE_W];
  logic [DATA_W-1:0]    slot_v0 [ISSUE_W];
  logic [DATA_W-1:0]    slot_v1 [ISSUE_W];
  logic [NUM_REGS-1:0]  clear_mask;
  logic [NUM_REGS-1:0]  set_mask;
  logic [NUM_REGS-1:0]  sb_eff;
  logic                 wb_err_now;
  logic [CNT_W-1:0]     deq_n;
  logic [NUM_WAYS-1:0]  way_sel;
  logic [SLOT_W-1:0]    way_slot [NUM_WAYS];

  // Ids at or above NUM_REGS name no register.
  function automatic logic in_range(input logic [REG_ID_W-1:0] id);
    return {1'b0, id} < NREG_LIM;
  endfunction

  function automatic logic [IDX_W-1:0] idx(input logic [REG_ID_W-1:0] id);
    return id[IDX_W-1:0];
  endfunction

  // Split the flat buses into per-slot and per-way fields.
  always_comb begin
    for (int k = 0; k < ISSUE_W; k++) begin
      s0_id[k] = bus.mop_src0[k*REG_ID_W +: REG_ID_W];
      s1_id[k] = bus.mop_src1[k*REG_ID_W +: REG_ID_W];
      d_id[k]  = bus.mop_dst[k*REG_ID_W +: REG_ID_W];
      s_pay[k] = bus.mop_payload[k*PAYLOAD_W +: PAYLOAD_W];
    end
    for (int w = 0; w < NUM_WAYS; w++) begin
      wb_id[w]   = bus.wb_dst[w*REG_ID_W +: REG_ID_W];
      wb_data[w] = bus.wb_val[w*DATA_W +: DATA_W];
    end
  end

  // Write-back decode: which scoreboard bits are released and whether the write-backs are illegal.
  always_comb begin
    clear_mask = '0;
    wb_err_now = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (bus.wb_valid[w] && in_range(wb_id[w])) begin
        clear_mask[idx(wb_id[w])] = 1'b1;
        if (!sb_pending[idx(wb_id[w])]) wb_err_now = 1'b1;
        for (int v = 0; v < w; v++) begin
          if (bus.wb_valid[v] && (wb_id[v] == wb_id[w])) wb_err_now = 1'b1;
        end
      end
    end
    sb_eff = sb_pending & ~clear_mask;
  end

  // Source read with write-first bypass; the lowest-numbered matching way wins.
  always_comb begin
    for (int k = 0; k < ISSUE_W; k++) begin
      slot_v0[k] = '0;
      slot_v1[k] = '0;
      if (in_range(s0_id[k])) begin
        slot_v0[k] = rf[idx(s0_id[k])];
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
          if (bus.wb_valid[w] && (wb_id[w] == s0_id[k])) slot_v0[k] = wb_data[w];
        end
      end
      if (in_range(s1_id[k])) begin
        slot_v1[k] = rf[idx(s1_id[k])];
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
          if (bus.wb_valid[w] && (wb_id[w] == s1_id[k])) slot_v1[k] = wb_data[w];
        end
      end
    end
  end

  // Eligibility scan: oldest first, stop at the first slot blocked by a hazard or by a lack of free ways.
  always_comb begin
    int  free_ways;
    int  n_elig;
    logic ok;
    free_ways = 0;
    n_elig    = 0;
    ok        = !reset;
    set_mask  = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!bus.way_busy[w]) free_ways++;
    end
    for (int k = 0; k < ISSUE_W; k++) begin
      if (k >= int'(bus.mop_avail)) ok = 1'b0;
      if (in_range(s0_id[k]) && sb_eff[idx(s0_id[k])]) ok = 1'b0;
      if (in_range(s1_id[k]) && sb_eff[idx(s1_id[k])]) ok = 1'b0;
      if (in_range(d_id[k]) && sb_eff[idx(d_id[k])]) ok = 1'b0;
      for (int j = 0; j < k; j++) begin
        if (in_range(d_id[j]) &&
            ((s0_id[k] == d_id[j]) || (s1_id[k] == d_id[j]) || (d_id[k] == d_id[j]))) ok = 1'b0;
      end
      if ((k + 1) > free_ways) ok = 1'b0;
      if (ok) begin
        n_elig++;
        if (in_range(d_id[k])) set_mask[idx(d_id[k])] = 1'b1;
      end
    end
    deq_n = CNT_W'(n_elig);
  end

  assign bus.deq_cnt = deq_n;

  // Way assignment: the k-th eligible slot goes to the k-th non-busy way.
  always_comb begin
    int rank;
    rank    = 0;
    way_sel = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      way_slot[w] = '0;
      if (!bus.way_busy[w]) begin
        if (rank < int'(deq_n)) begin
          way_sel[w]  = 1'b1;
          way_slot[w] = SLOT_W'(rank);
        end
        rank++;
      end
    end
  end

  // State update: register file, scoreboard, counters, error flag and issue registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) rf[r] <= '0;
      sb_pending       <= '0;
      stall_cnt        <= '0;
      err_wb           <= 1'b0;
      bus.iss_valid    <= '0;
      bus.iss_src0_val <= '0;
      bus.iss_src1_val <= '0;
      bus.iss_dst      <= '0;
      bus.iss_payload  <= '0;
    end else begin
      sb_pending <= sb_eff | set_mask;
      if (wb_err_now) err_wb <= 1'b1;
      if ((bus.mop_avail != '0) && (deq_n == '0) && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
        if (bus.wb_valid[w] && in_range(wb_id[w])) rf[idx(wb_id[w])] <= wb_data[w];
      end
      for (int w = 0; w < NUM_WAYS; w++) begin
        bus.iss_valid[w] <= way_sel[w];
        if (way_sel[w]) begin
          bus.iss_src0_val[w*DATA_W +: DATA_W]     <= slot_v0[way_slot[w]];
          bus.iss_src1_val[w*DATA_W +: DATA_W]     <= slot_v1[way_slot[w]];
          bus.iss_dst[w*REG_ID_W +: REG_ID_W]      <= d_id[way_slot[w]];
          bus.iss_payload[w*PAYLOAD_W +: PAYLOAD_W] <= s_pay[way_slot[w]];
        end
      end
    end
  end
endmodule

// File: tb/tb_multi_issue_dispatch.sv
// Self-checking bench for multi_issue_dispatch: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model of the dispatch rules.
module tb_multi_issue_dispatch;
  localparam int NUM_REGS  = 16;
  localparam int REG_ID_W  = 5;
  localparam int DATA_W    = 64;
  localparam int PAYLOAD_W = 32;
  localparam int ISSUE_W   = 2;
  localparam int NUM_WAYS  = 2;
  localparam int CNT_W     = $clog2(ISSUE_W + 1);

  logic clk = 1'b0;
  logic reset;
  logic [NUM_REGS-1:0] sb_pending;
  logic [31:0]         stall_cnt;
  logic                err_wb;

  int n_checks = 0;
  int n_errors = 0;
  int obs_deq;

  // stimulus for the next cycle
  int                   st_avail;
  int                   st_src0 [ISSUE_W];
  int                   st_src1 [ISSUE_W];
  int                   st_dst [ISSUE_W];
  logic [PAYLOAD_W-1:0] st_pay [ISSUE_W];
  bit                   st_busy [NUM_WAYS];
  bit                   st_wbv [NUM_WAYS];
  int                   st_wbd [NUM_WAYS];
  logic [DATA_W-1:0]    st_wbval [NUM_WAYS];

  // reference model state and expectations
  logic [DATA_W-1:0]    m_rf [NUM_REGS];
  bit                   m_pend [NUM_REGS];
  bit                   m_err;
  logic [31:0]          m_stall;
  logic [DATA_W-1:0]    n_rf [NUM_REGS];
  bit                   n_pend [NUM_REGS];
  bit                   n_err;
  logic [31:0]          n_stall;
  int                   exp_deq;
  bit                   exp_iv [NUM_WAYS];
  logic [DATA_W-1:0]    exp_v0 [NUM_WAYS];
  logic [DATA_W-1:0]    exp_v1 [NUM_WAYS];
  int                   exp_dst [NUM_WAYS];
  logic [PAYLOAD_W-1:0] exp_pay [NUM_WAYS];

  always #5 clk = ~clk;

  multi_issue_dispatch_if #(
    .REG_ID_W(REG_ID_W), .DATA_W(DATA_W), .PAYLOAD_W(PAYLOAD_W),
    .ISSUE_W(ISSUE_W), .NUM_WAYS(NUM_WAYS)
  ) bus ();

  multi_issue_dispatch #(
    .NUM_REGS(NUM_REGS), .REG_ID_W(REG_ID_W), .DATA_W(DATA_W), .PAYLOAD_W(PAYLOAD_W),
    .ISSUE_W(ISSUE_W), .NUM_WAYS(NUM_WAYS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .sb_pending(sb_pending),
    .stall_cnt(stall_cnt),
    .err_wb(err_wb)
  );

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_stim();
    st_avail = 0;
    for (int k = 0; k < ISSUE_W; k++) begin
      st_src0[k] = 31; st_src1[k] = 31; st_dst[k] = 31; st_pay[k] = '0;
    end
    for (int w = 0; w < NUM_WAYS; w++) begin
      st_busy[w] = 1'b0; st_wbv[w] = 1'b0; st_wbd[w] = 31; st_wbval[w] = '0;
    end
  endtask

  task automatic set_slot(input int k, input int s0, input int s1, input int d, input logic [PAYLOAD_W-1:0] p);
    st_src0[k] = s0; st_src1[k] = s1; st_dst[k] = d; st_pay[k] = p;
  endtask

  task automatic set_wb(input int w, input int d, input logic [DATA_W-1:0] v);
    st_wbv[w] = 1'b1; st_wbd[w] = d; st_wbval[w] = v;
  endtask

  task automatic drive();
    bus.mop_avail = CNT_W'(st_avail);
    for (int k = 0; k < ISSUE_W; k++) begin
      bus.mop_src0[k*REG_ID_W +: REG_ID_W]       = REG_ID_W'(st_src0[k]);
      bus.mop_src1[k*REG_ID_W +: REG_ID_W]       = REG_ID_W'(st_src1[k]);
      bus.mop_dst[k*REG_ID_W +: REG_ID_W]        = REG_ID_W'(st_dst[k]);
      bus.mop_payload[k*PAYLOAD_W +: PAYLOAD_W]  = st_pay[k];
    end
    for (int w = 0; w < NUM_WAYS; w++) begin
      bus.way_busy[w]                      = st_busy[w];
      bus.wb_valid[w]                      = st_wbv[w];
      bus.wb_dst[w*REG_ID_W +: REG_ID_W]   = REG_ID_W'(st_wbd[w]);
      bus.wb_val[w*DATA_W +: DATA_W]       = st_wbval[w];
    end
  endtask

  // Register value as seen by a reader this cycle: first matching write-back, else the file.
  function automatic logic [DATA_W-1:0] rd(input int id);
    if (id >= NUM_REGS) return '0;
    for (int w = 0; w < NUM_WAYS; w++) if (st_wbv[w] && st_wbd[w] == id) return st_wbval[w];
    return m_rf[id];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NUM_REGS; r++) begin m_rf[r] = '0; m_pend[r] = 1'b0; end
    m_err = 1'b0; m_stall = '0;
    for (int w = 0; w < NUM_WAYS; w++) exp_iv[w] = 1'b0;
  endtask

  // Reference model: greedy in-order group formation using queues of free ways and claimed dsts.
  task automatic model_comb();
    bit cleared [NUM_REGS];
    bit written [NUM_REGS];
    int free_ways [$];
    int grp_dst [$];
    int issued [$];
    int ids [3];
    bit blocked;
    for (int r = 0; r < NUM_REGS; r++) begin cleared[r] = 0; written[r] = 0; end
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (st_wbv[w] && st_wbd[w] < NUM_REGS) cleared[st_wbd[w]] = 1;
      if (!st_busy[w]) free_ways.push_back(w);
    end
    for (int k = 0; k < ISSUE_W; k++) begin
      if (k >= st_avail) break;
      ids = '{st_src0[k], st_src1[k], st_dst[k]};
      blocked = 0;
      foreach (ids[i]) begin
        if (ids[i] < NUM_REGS && m_pend[ids[i]] && !cleared[ids[i]]) blocked = 1;
        foreach (grp_dst[g]) if (ids[i] == grp_dst[g]) blocked = 1;
      end
      if (issued.size() >= free_ways.size()) blocked = 1;
      if (blocked) break;
      issued.push_back(k);
      if (st_dst[k] < NUM_REGS) grp_dst.push_back(st_dst[k]);
    end
    exp_deq = issued.size();
    for (int w = 0; w < NUM_WAYS; w++) exp_iv[w] = 0;
    foreach (issued[i]) begin
      int w = free_ways[i];
      int k = issued[i];
      exp_iv[w]  = 1;
      exp_v0[w]  = rd(st_src0[k]);
      exp_v1[w]  = rd(st_src1[k]);
      exp_dst[w] = st_dst[k];
      exp_pay[w] = st_pay[k];
    end
    n_rf = m_rf;
    n_err = m_err;
    for (int r = 0; r < NUM_REGS; r++) n_pend[r] = m_pend[r] && !cleared[r];
    foreach (grp_dst[g]) n_pend[grp_dst[g]] = 1;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (st_wbv[w] && st_wbd[w] < NUM_REGS) begin
        if (!m_pend[st_wbd[w]]) n_err = 1;
        if (written[st_wbd[w]]) n_err = 1;
        else begin n_rf[st_wbd[w]] = st_wbval[w]; written[st_wbd[w]] = 1; end
      end
    end
    n_stall = (st_avail > 0 && exp_deq == 0 && m_stall != 32'hFFFF_FFFF) ? m_stall + 1 : m_stall;
  endtask

  task automatic model_commit();
    m_rf = n_rf; m_pend = n_pend; m_err = n_err; m_stall = n_stall;
  endtask

  function automatic logic [NUM_REGS-1:0] pend_vec();
    logic [NUM_REGS-1:0] v;
    for (int r = 0; r < NUM_REGS; r++) v[r] = m_pend[r];
    return v;
  endfunction

  function automatic bit any_pending();
    for (int r = 0; r < NUM_REGS; r++) if (m_pend[r]) return 1;
    return 0;
  endfunction

  task automatic check_regs();
    for (int w = 0; w < NUM_WAYS; w++) begin
      checkOutput($sformatf("iss_valid[%0d]", w), 64'(bus.iss_valid[w]), 64'(exp_iv[w]));
      if (exp_iv[w]) begin
        checkOutput($sformatf("iss_src0_val[%0d]", w), bus.iss_src0_val[w*DATA_W +: DATA_W], exp_v0[w]);
        checkOutput($sformatf("iss_src1_val[%0d]", w), bus.iss_src1_val[w*DATA_W +: DATA_W], exp_v1[w]);
        checkOutput($sformatf("iss_dst[%0d]", w), 64'(bus.iss_dst[w*REG_ID_W +: REG_ID_W]), 64'(exp_dst[w]));
        checkOutput($sformatf("iss_payload[%0d]", w), 64'(bus.iss_payload[w*PAYLOAD_W +: PAYLOAD_W]), 64'(exp_pay[w]));
      end
    end
    checkOutput("sb_pending", 64'(sb_pending), 64'(pend_vec()));
    checkOutput("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    checkOutput("err_wb", 64'(err_wb), 64'(m_err));
  endtask

  // One clock of traffic: drive after the falling edge, check deq_cnt, then registered state after the rising edge.
  task automatic applyStimulus();
    @(negedge clk);
    reset = 1'b0;
    drive();
    #1;
    model_comb();
    obs_deq = int'(bus.deq_cnt);
    checkOutput("deq_cnt", 64'(bus.deq_cnt), 64'(exp_deq));
    @(posedge clk);
    #1;
    model_commit();
    check_regs();
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    drive();
    #1;
    checkOutput("deq_cnt_in_reset", 64'(bus.deq_cnt), 64'd0);
    @(posedge clk);
    #1;
    model_reset();
    checkOutput("iss_valid_reset", 64'(bus.iss_valid), 64'd0);
    checkOutput("sb_pending_reset", 64'(sb_pending), 64'd0);
    checkOutput("stall_cnt_reset", 64'(stall_cnt), 64'd0);
    checkOutput("err_wb_reset", 64'(err_wb), 64'd0);
  endtask

  function automatic int rand_id();
    if ($urandom_range(0, 9) == 0) return 31;
    return int'($urandom_range(0, NUM_REGS - 1));
  endfunction

  // Random pipelines return write-backs only for registers the model holds pending, each at most once per cycle.
  task automatic gen_wb();
    int cand [$];
    int pick;
    for (int r = 0; r < NUM_REGS; r++) if (m_pend[r]) cand.push_back(r);
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
        pick = int'($urandom_range(0, cand.size() - 1));
        set_wb(w, cand[pick], {$urandom, $urandom});
        cand.delete(pick);
      end else if ($urandom_range(0, 15) == 0) begin
        set_wb(w, 31, {$urandom, $urandom});
      end
    end
  endtask

  task automatic gen_random();
    clear_stim();
    st_avail = int'($urandom_range(0, ISSUE_W));
    for (int k = 0; k < ISSUE_W; k++) set_slot(k, rand_id(), rand_id(), rand_id(), $urandom);
    for (int w = 0; w < NUM_WAYS; w++) st_busy[w] = ($urandom_range(0, 3) == 0);
    gen_wb();
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] stall_ref;
    // power-on reset with ops presented at the queue head
    reset = 1'b1;
    clear_stim();
    set_slot(0, 31, 31, 1, 32'h1); set_slot(1, 31, 31, 2, 32'h2); st_avail = 2;
    drive();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checkOutput("deq_cnt_por", 64'(bus.deq_cnt), 64'd0);
    check_regs();

    // preload R3=5, R4=7
    clear_stim(); set_slot(0, 31, 31, 3, 32'h10); set_slot(1, 31, 31, 4, 32'h11); st_avail = 2;
    applyStimulus();
    clear_stim(); set_wb(0, 3, 64'd5); set_wb(1, 4, 64'd7);
    applyStimulus();

    // independent pair on two free ways
    clear_stim(); set_slot(0, 31, 31, 1, 32'hA0); set_slot(1, 3, 4, 2, 32'hA1); st_avail = 2;
    applyStimulus();
    checkOutput("indep_deq", 64'(obs_deq), 64'd2);
    checkOutput("indep_valid", 64'(bus.iss_valid), 64'b11);
    checkOutput("indep_src0", bus.iss_src0_val[DATA_W +: DATA_W], 64'd5);
    checkOutput("indep_src1", bus.iss_src1_val[DATA_W +: DATA_W], 64'd7);
    checkOutput("indep_sb", 64'(sb_pending), 64'h0006);
    clear_stim(); set_wb(0, 1, 64'h11); set_wb(1, 2, 64'h22);
    applyStimulus();

    // intra-group RAW, then bypassed release
    clear_stim(); set_slot(0, 31, 31, 1, 32'hB0); set_slot(1, 1, 31, 5, 32'hB1); st_avail = 2;
    applyStimulus();
    checkOutput("raw_deq", 64'(obs_deq), 64'd1);
    checkOutput("raw_valid", 64'(bus.iss_valid), 64'b01);
    clear_stim(); set_slot(0, 1, 31, 5, 32'hB1); st_avail = 1; set_wb(0, 1, 64'h55);
    applyStimulus();
    checkOutput("raw_bypass_deq", 64'(obs_deq), 64'd1);
    checkOutput("raw_bypass_val", bus.iss_src0_val[0 +: DATA_W], 64'h55);
    clear_stim(); set_wb(0, 5, 64'h5);
    applyStimulus();

    // busy way 0
    stall_ref = m_stall;
    clear_stim(); set_slot(0, 31, 31, 7, 32'hC0); set_slot(1, 31, 31, 8, 32'hC1); st_avail = 2; st_busy[0] = 1;
    applyStimulus();
    checkOutput("busy_deq", 64'(obs_deq), 64'd1);
    checkOutput("busy_valid", 64'(bus.iss_valid), 64'b10);
    checkOutput("busy_stall", 64'(stall_cnt), 64'(stall_ref));
    clear_stim(); set_wb(0, 7, 64'h7);
    applyStimulus();

    // WAW stall on R6 and release with set-wins
    clear_stim(); set_slot(0, 31, 31, 6, 32'hD0); st_avail = 1;
    applyStimulus();
    stall_ref = m_stall;
    for (int i = 0; i < 3; i++) begin
      clear_stim(); set_slot(0, 31, 31, 6, 32'hD1); st_avail = 1;
      applyStimulus();
      checkOutput("waw_deq", 64'(obs_deq), 64'd0);
    end
    checkOutput("waw_stall", 64'(stall_cnt), 64'(stall_ref + 32'd3));
    clear_stim(); set_slot(0, 31, 31, 6, 32'hD1); st_avail = 1; set_wb(1, 6, 64'h66);
    applyStimulus();
    checkOutput("waw_release_deq", 64'(obs_deq), 64'd1);
    checkOutput("waw_set_wins", 64'(sb_pending[6]), 64'd1);
    clear_stim(); set_wb(0, 6, 64'h67);
    applyStimulus();

    // out-of-range ids
    clear_stim(); set_slot(0, 31, 31, 31, 32'hE0); st_avail = 1;
    applyStimulus();
    checkOutput("oor_deq", 64'(obs_deq), 64'd1);
    checkOutput("oor_src0", bus.iss_src0_val[0 +: DATA_W], 64'd0);
    checkOutput("oor_sb", 64'(sb_pending), 64'd0);

    // randomized traffic
    for (int c = 0; c < 500; c++) begin
      gen_random();
      applyStimulus();
    end

    // drain outstanding registers
    for (int c = 0; c < 60 && any_pending(); c++) begin
      clear_stim(); gen_wb();
      applyStimulus();
    end
    checkOutput("drained_sb", 64'(sb_pending), 64'd0);

    // write-back to a register that is not pending
    clear_stim(); set_wb(0, 9, 64'h99);
    applyStimulus();
    checkOutput("err_set", 64'(err_wb), 64'd1);
    clear_stim();
    applyStimulus();
    checkOutput("err_sticky", 64'(err_wb), 64'd1);

    // reset in the middle of issue
    clear_stim(); set_slot(0, 31, 31, 10, 32'hF0); set_slot(1, 31, 31, 11, 32'hF1); st_avail = 2;
    applyStimulus();
    set_wb(0, 10, 64'hAA);
    doReset();
    clear_stim(); set_slot(0, 3, 1, 2, 32'hF2); st_avail = 1;
    applyStimulus();
    checkOutput("post_reset_src0", bus.iss_src0_val[0 +: DATA_W], 64'd0);
    checkOutput("post_reset_src1", bus.iss_src1_val[0 +: DATA_W], 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/multi_issue_dispatch.md
Name: multi_issue_dispatch

Overview:
- Parametrised register-read, dispatch and write-back stage for the Musk core.
- Each cycle it takes up to ISSUE_W in-order micro-ops from the head of the decode queue and checks them against a scoreboard and against each other.
- It reads their source values from the register file and dispatches them to NUM_WAYS independent execution pipelines.
- It retires write-backs from all pipelines into the register file and scoreboard.

Parameters:
- NUM_REGS, 16, architectural registers held in the file.
- REG_ID_W, 5, register-id width. Ids >= NUM_REGS mean "no register".
- DATA_W, 64, register value width.
- PAYLOAD_W, 32, opaque op/immediate bits carried to the pipeline unchanged.
- ISSUE_W, 2, micro-ops examined per cycle.
- NUM_WAYS, 2, execution pipelines (NUM_WAYS >= 1, ISSUE_W >= 1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- mop_avail  in  $clog2(ISSUE_W+1)  number of valid micro-ops at the queue head (0..ISSUE_W)
- mop_src0  in  ISSUE_W*REG_ID_W  source-0 id per slot; slot 0 is oldest
- mop_src1  in  ISSUE_W*REG_ID_W  source-1 id per slot
- mop_dst  in  ISSUE_W*REG_ID_W  destination id per slot
- mop_payload  in  ISSUE_W*PAYLOAD_W  payload per slot
- deq_cnt  out  $clog2(ISSUE_W+1)  micro-ops consumed this cycle (combinational)
- way_busy  in  NUM_WAYS  pipeline cannot accept an op this cycle
- iss_valid  out  NUM_WAYS  registered issue strobe
- iss_src0_val  out  NUM_WAYS*DATA_W  registered source-0 value
- iss_src1_val  out  NUM_WAYS*DATA_W  registered source-1 value
- iss_dst  out  NUM_WAYS*REG_ID_W  registered destination id
- iss_payload  out  NUM_WAYS*PAYLOAD_W  registered payload
- wb_valid  in  NUM_WAYS  write-back strobe per pipeline
- wb_dst  in  NUM_WAYS*REG_ID_W  write-back destination id
- wb_val  in  NUM_WAYS*DATA_W  write-back value
- sb_pending  out  NUM_REGS  scoreboard state (flop view)
- stall_cnt  out  32  cycles with mop_avail>0 and deq_cnt==0; saturating
- err_wb  out  1  sticky error flag

Behaviour:
- Reset: register file, sb_pending, iss_valid, stall_cnt, err_wb all 0. deq_cnt is 0 while reset is high. An op in flight when reset asserts is discarded; its later wb_valid is ignored until reset deasserts.
- Effective scoreboard this cycle: sb_eff = sb_pending & ~clear_mask, where clear_mask holds bits for in-range wb_dst with wb_valid set. Same-cycle write-back therefore releases a hazard.
- Register read is write-first: a source whose id matches a same-cycle write-back gets wb_val. If several match, the lowest way index wins.
- Slot k is eligible when all of the following hold:
  - k < mop_avail;
  - every slot j<k is eligible;
  - its in-range sources and in-range dst are not set in sb_eff (RAW and WAW);
  - its sources and dst do not match the in-range dst of any older slot in the group;
  - enough free ways exist: the count of eligible slots up to k is <= the count of zeros in way_busy.
- deq_cnt = number of eligible slots; the rule keeps them a prefix.
- Way assignment: eligible slot k goes to the k-th non-busy way in ascending index. Unassigned ways get iss_valid=0 next cycle.
- Issue latency 1 cycle. On the next edge the assigned way's iss_* registers load: iss_valid=1, values, dst, payload. iss_valid stays high for exactly one cycle per op, with no back-pressure after issue.
- Out-of-range source reads return 0. An out-of-range dst sets no scoreboard bit.
- Scoreboard next = (sb_pending & ~clear_mask) | set_mask. If a register is both cleared and set in the same cycle, set wins.
- Register file: on wb_valid with in-range dst, write wb_val. Out-of-range wb_dst is ignored.
- err_wb sets, sticky until reset, when either:
  - wb_valid targets an in-range register whose sb_pending bit is 0; or
  - two ways write back the same in-range register in one cycle (the lower index is written).
- stall_cnt saturates at 2^32-1.

Test Plan:
- Independent ops, ISSUE_W=2, NUM_WAYS=2, all ways free. Slot0 dst=R1, slot1 dst=R2 with src R3/R4 (R3=5, R4=7) -> deq_cnt=2; next cycle iss_valid=2'b11, way1 src vals 5,7; sb_pending bits 1,2 set.
- Intra-group RAW. Slot0 dst=R1, slot1 src0=R1 -> deq_cnt=1, only way0 issues, slot1 waits. Way0 write-backs R1=0x55; in that same cycle slot1 issues with src0_val=0x55 (bypass) and deq_cnt=1.
- Busy way. way_busy=2'b01, two independent ops -> deq_cnt=1 and slot0 goes to way1. stall_cnt unchanged.
- WAW stall. R6 pending, slot0 dst=R6 -> deq_cnt=0 and stall_cnt increments each cycle. Release: wb R6 arrives and same cycle deq_cnt=1; R6 stays pending (set wins).
- Error and reset. wb_valid to a non-pending R9 -> err_wb=1 next cycle and stays high. Then assert reset mid-issue -> all outputs 0, deq_cnt=0, regfile reads 0.
- Out-of-range ids. src=31 and dst=31 -> src val 0, no scoreboard change, op still issues.
